alu_op_sequencer: RTL and testbench

- Parametrised control-step sequencer for the bus-based datapath. Drives fetch (T0–T2) and execute steps for register-register and register-unary ALU instructions.
- Generalises the fixed single-instruction control sequence to any supported opcode, a configurable register count, memory wait states, multi-cycle ALU ops, and HI/LO wide results.
- Sits between the IR output and the datapath control inputs.

---
 rtl/alu_op_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer for the bus-based datapath: fetch (T0-T2) plus execute
// steps for register-register, register-unary and wide (HI/LO) ALU instructions.
module alu_op_sequencer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned OPCODE_W   = 5,
    parameter int unsigned ALU_OP_W   = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DATA_W-1:0]     ir_q,
    input  logic                  mem_ready,
    input  logic                  alu_done,
    output logic                  PCout,
    output logic                  IncPC,
    output logic                  MARin,
    output logic                  Zin,
    output logic                  Zlowout,
    output logic                  Zhighout,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  HIin,
    output logic                  LOin,
    output logic [NUM_REGS-1:0]   rin,
    output logic [NUM_REGS-1:0]   rout,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);

    localparam int unsigned RA_LSB = DATA_W - OPCODE_W - REG_ADDR_W;
    localparam int unsigned RB_LSB = RA_LSB - REG_ADDR_W;
    localparam int unsigned RC_LSB = RB_LSB - REG_ADDR_W;
    localparam int unsigned CTRL_W = 13;

    localparam int unsigned C_PCOUT  = 0;
    localparam int unsigned C_INCPC  = 1;
    localparam int unsigned C_MARIN  = 2;
    localparam int unsigned C_ZIN    = 3;
    localparam int unsigned C_ZLOW   = 4;
    localparam int unsigned C_ZHIGH  = 5;
    localparam int unsigned C_READ   = 6;
    localparam int unsigned C_MDRIN  = 7;
    localparam int unsigned C_MDROUT = 8;
    localparam int unsigned C_IRIN   = 9;
    localparam int unsigned C_YIN    = 10;
    localparam int unsigned C_HIIN   = 11;
    localparam int unsigned C_LOIN   = 12;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_e;

    typedef enum logic [1:0] {K_BIN, K_WIDE, K_UNARY, K_ILL} kind_e;

    state_e                state_q, state_d;
    kind_e                 kind_q, kind_d, dec_kind;
    logic [REG_ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d, dec_alu_op;
    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [NUM_REGS-1:0]   rin_q, rin_d, rout_q, rout_d;
    logic                  busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
    logic [OPCODE_W-1:0]   opcode;
    logic                  ir_unused;

    assign ir_unused = ^ir_q[RC_LSB-1:0];

    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Opcode class and encoded ALU operation
    always_comb begin
        opcode     = ir_q[DATA_W-1 -: OPCODE_W];
        dec_kind   = K_ILL;
        dec_alu_op = '0;
        if (opcode <= OPCODE_W'(7)) begin
            dec_kind   = K_BIN;
            dec_alu_op = ALU_OP_W'(opcode[3:0]);
        end else if (opcode == OPCODE_W'(15)) begin
            dec_kind   = K_WIDE;
            dec_alu_op = ALU_OP_W'(4'hF);
        end else if (opcode == OPCODE_W'(16)) begin
            dec_kind   = K_WIDE;
            dec_alu_op = ALU_OP_W'(4'hE);
        end else if (opcode == OPCODE_W'(17)) begin
            dec_kind   = K_UNARY;
            dec_alu_op = ALU_OP_W'(4'hD);
        end else if (opcode == OPCODE_W'(18)) begin
            dec_kind   = K_UNARY;
            dec_alu_op = ALU_OP_W'(4'hC);
        end
    end

    // Next state, operand latches, and next-cycle outputs decoded from the next state
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rc_d      = rc_q;
        alu_op_d  = alu_op_q;
        illegal_d = 1'b0;
        ctrl_d    = '0;
        rin_d     = '0;
        rout_d    = '0;

        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (mem_ready) state_d = S_T2;
            S_T2: begin
                if (dec_kind == K_ILL) begin
                    state_d   = S_IDLE;
                    illegal_d = 1'b1;
                end else begin
                    state_d  = (dec_kind == K_UNARY) ? S_T4 : S_T3;
                    kind_d   = dec_kind;
                    ra_d     = ir_q[RA_LSB +: REG_ADDR_W];
                    rb_d     = ir_q[RB_LSB +: REG_ADDR_W];
                    rc_d     = ir_q[RC_LSB +: REG_ADDR_W];
                    alu_op_d = dec_alu_op;
                end
            end
            S_T3:   state_d = S_T4;
            S_T4:   if (kind_q != K_WIDE || alu_done) state_d = S_T5;
            S_T5:   state_d = (kind_q == K_WIDE) ? S_T6 : S_DONE;
            S_T6:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_T0: begin
                ctrl_d[C_PCOUT] = 1'b1;
                ctrl_d[C_INCPC] = 1'b1;
                ctrl_d[C_ZIN]   = 1'b1;
                ctrl_d[C_MARIN] = 1'b1;
            end
            S_T1: begin
                ctrl_d[C_ZLOW]  = 1'b1;
                ctrl_d[C_READ]  = 1'b1;
                ctrl_d[C_MDRIN] = 1'b1;
            end
            S_T2: begin
                ctrl_d[C_MDROUT] = 1'b1;
                ctrl_d[C_IRIN]   = 1'b1;
            end
            S_T3: begin
                ctrl_d[C_YIN] = 1'b1;
                rout_d        = onehot(rb_d);
            end
            S_T4: begin
                ctrl_d[C_ZIN] = 1'b1;
                rout_d        = onehot((kind_d == K_UNARY) ? rb_d : rc_d);
            end
            S_T5: begin
                ctrl_d[C_ZLOW] = 1'b1;
                if (kind_d == K_WIDE) ctrl_d[C_LOIN] = 1'b1;
                else                  rin_d          = onehot(ra_d);
            end
            S_T6: begin
                ctrl_d[C_ZHIGH] = 1'b1;
                ctrl_d[C_HIIN]  = 1'b1;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            kind_q    <= K_BIN;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            alu_op_q  <= '0;
            ctrl_q    <= '0;
            rin_q     <= '0;
            rout_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rc_q      <= rc_d;
            alu_op_q  <= alu_op_d;
            ctrl_q    <= ctrl_d;
            rin_q     <= rin_d;
            rout_q    <= rout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign PCout    = ctrl_q[C_PCOUT];
    assign IncPC    = ctrl_q[C_INCPC];
    assign MARin    = ctrl_q[C_MARIN];
    assign Zin      = ctrl_q[C_ZIN];
    assign Zlowout  = ctrl_q[C_ZLOW];
    assign Zhighout = ctrl_q[C_ZHIGH];
    assign Read     = ctrl_q[C_READ];
    assign MDRin    = ctrl_q[C_MDRIN];
    assign MDRout   = ctrl_q[C_MDROUT];
    assign IRin     = ctrl_q[C_IRIN];
    assign Yin      = ctrl_q[C_YIN];
    assign HIin     = ctrl_q[C_HIIN];
    assign LOin     = ctrl_q[C_LOIN];
    assign rin      = rin_q;
    assign rout     = rout_q;
    assign alu_op   = alu_op_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised bench for alu_op_sequencer: a per-instruction list of expected
// control steps is built from the opcode rules and checked every cycle.
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, mem_ready, alu_done;
    logic [31:0] ir_q;
    logic        PCout, IncPC, MARin, Zin, Zlowout, Zhighout, Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [15:0] rin, rout;
    logic [3:0]  alu_op;
    logic        busy, done, illegal;

    always #5 clock = ~clock;

    alu_op_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .ir_q(ir_q),
        .mem_ready(mem_ready), .alu_done(alu_done),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .rin(rin), .rout(rout), .alu_op(alu_op),
        .busy(busy), .done(done), .illegal(illegal)
    );

    localparam logic [12:0] K_PCOUT  = 13'h1000, K_INCPC = 13'h0800, K_MARIN = 13'h0400;
    localparam logic [12:0] K_ZIN    = 13'h0200, K_ZLO   = 13'h0100, K_ZHI   = 13'h0080;
    localparam logic [12:0] K_READ   = 13'h0040, K_MDRIN = 13'h0020, K_MDROUT = 13'h0010;
    localparam logic [12:0] K_IRIN   = 13'h0008, K_YIN   = 13'h0004, K_HIIN  = 13'h0002;
    localparam logic [12:0] K_LOIN   = 13'h0001;

    typedef struct packed {
        logic [12:0] ctrl;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [3:0]  aop;
        logic        aop_chk;
        logic        busy;
        logic        done;
        logic        ill;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        exp_now;
    logic        exp_valid = 1'b0;
    logic        exp_last  = 1'b0;
    int          cyc = -1;
    int          pin_sel = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] obs_rout[64];
    logic [15:0] obs_rin[64];
    logic [12:0] obs_ctrl[64];
    logic [3:0]  obs_aop[64];
    logic        obs_ill[64];
    int          done_seen;
    logic [15:0] rin_acc;
    logic [12:0] ctrl_acc;
    logic [12:0] dut_ctrl;

    assign dut_ctrl = {PCout, IncPC, MARin, Zin, Zlowout, Zhighout, Read, MDRin, MDRout, IRin, Yin, HIin, LOin};

    // kind: 0 binary, 1 wide, 2 unary, 3 illegal
    function automatic void classify(input logic [4:0] op, output int kind, output logic [3:0] aop);
        kind = 3;
        aop  = 4'h0;
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: begin kind = 0; aop = op[3:0]; end
            5'b01111: begin kind = 1; aop = 4'hF; end
            5'b10000: begin kind = 1; aop = 4'hE; end
            5'b10001: begin kind = 2; aop = 4'hD; end
            5'b10010: begin kind = 2; aop = 4'hC; end
            default: ;
        endcase
    endfunction

    task automatic build(input logic [31:0] ir, input int mw, input int aw);
        int          kind;
        logic [3:0]  aop, ra, rb, rc;
        rec_t        r;
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];
        classify(ir[31:27], kind, aop);
        exp_q.delete();
        r = '0; r.busy = 1'b1; r.ctrl = K_PCOUT | K_INCPC | K_ZIN | K_MARIN;
        exp_q.push_back(r);
        r.ctrl = K_ZLO | K_READ | K_MDRIN;
        repeat (mw + 1) exp_q.push_back(r);
        r.ctrl = K_MDROUT | K_IRIN;
        exp_q.push_back(r);
        if (kind == 3) begin
            r = '0; r.ill = 1'b1; exp_q.push_back(r);
            r = '0; exp_q.push_back(r);
            return;
        end
        if (kind != 2) begin
            r = '0; r.busy = 1'b1; r.ctrl = K_YIN; r.rout = 16'd1 << rb;
            exp_q.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.ctrl = K_ZIN; r.aop = aop; r.aop_chk = 1'b1;
        r.rout = 16'd1 << ((kind == 2) ? rb : rc);
        repeat ((kind == 1) ? aw + 1 : 1) exp_q.push_back(r);
        r = '0; r.busy = 1'b1;
        r.ctrl = K_ZLO | ((kind == 1) ? K_LOIN : 13'h0);
        r.rin  = (kind == 1) ? 16'h0 : (16'd1 << ra);
        exp_q.push_back(r);
        if (kind == 1) begin
            r = '0; r.busy = 1'b1; r.ctrl = K_ZHI | K_HIIN;
            exp_q.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1; exp_q.push_back(r);
        r = '0; exp_q.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    // Hand-computed expectations for the directed instructions
    task automatic pins();
        case (pin_sel)
            1: begin
                chk("or_t3_rout", obs_rout[4], 16'h0004);
                chk("or_t3_yin", obs_ctrl[4] & K_YIN, K_YIN);
                chk("or_t4_rout", obs_rout[5], 16'h0008);
                chk("or_t4_aop", obs_aop[5], 4'h3);
                chk("or_t5_rin", obs_rin[6], 16'h0002);
                chk("or_latency", done_seen, 7);
            end
            2: begin
                chk("mul_latency", done_seen, 13);
                chk("mul_t5_loin", obs_ctrl[11] & K_LOIN, K_LOIN);
                chk("mul_t6_hi", obs_ctrl[12] & (K_ZHI | K_HIIN), K_ZHI | K_HIIN);
                chk("mul_rin_never", rin_acc, 16'h0);
            end
            3: begin
                chk("not_t4_rout", obs_rout[4], 16'h0200);
                chk("not_t4_aop", obs_aop[4], 4'hC);
                chk("not_t5_rin", obs_rin[5], 16'h0080);
                chk("not_no_yin", ctrl_acc & K_YIN, 13'h0);
                chk("not_latency", done_seen, 6);
            end
            4: begin
                chk("ill_pulse", obs_ill[4], 1'b1);
                chk("ill_no_done", done_seen, 0);
                chk("ill_no_rin", rin_acc, 16'h0);
            end
            default: ;
        endcase
    endtask

    // Cycle-by-cycle comparison against the expected step list
    always @(negedge clock) begin
        if (exp_valid) begin
            if (cyc == 1) begin
                done_seen = 0;
                rin_acc   = '0;
                ctrl_acc  = '0;
            end
            chk("ctrl", dut_ctrl, exp_now.ctrl);
            chk("rin", rin, exp_now.rin);
            chk("rout", rout, exp_now.rout);
            chk("busy_done_ill", {busy, done, illegal}, {exp_now.busy, exp_now.done, exp_now.ill});
            if (exp_now.aop_chk) chk("alu_op", alu_op, exp_now.aop);
            if (cyc >= 1 && cyc < 64) begin
                obs_rout[cyc] = rout;
                obs_rin[cyc]  = rin;
                obs_ctrl[cyc] = dut_ctrl;
                obs_aop[cyc]  = alu_op;
                obs_ill[cyc]  = illegal;
                if (done === 1'b1 && done_seen == 0) done_seen = cyc;
                rin_acc  = rin_acc | rin;
                ctrl_acc = ctrl_acc | dut_ctrl;
            end
            if (exp_last) pins();
        end
    end

    task automatic run(input logic [31:0] ir, input int mw, input int aw, input int abort_at, input int sel);
        int         kind;
        logic [3:0] aop;
        int         t4s;
        build(ir, mw, aw);
        classify(ir[31:27], kind, aop);
        t4s       = mw + 5;
        pin_sel   = sel;
        exp_last  = 1'b0;
        cyc       = 0;
        ir_q      = ir;
        start     = 1'b1;
        clear     = 1'b0;
        mem_ready = 1'($urandom);
        alu_done  = 1'($urandom);
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(posedge clock);
            #1;
            cyc = c;
            if (abort_at > 0 && c == abort_at + 1) begin
                exp_now = '0;
                exp_now.aop_chk = 1'b1;
                exp_last = 1'b1;
                start = 1'b0;
                clear = 1'b0;
                break;
            end
            exp_now  = exp_q[c-1];
            exp_last = (c == exp_q.size());
            start    = exp_now.busy ? 1'($urandom) : 1'b0;
            clear    = (c == abort_at);
            if (c >= 2 && c <= mw + 1)  mem_ready = 1'b0;
            else if (c == mw + 2)       mem_ready = 1'b1;
            else                        mem_ready = 1'($urandom);
            if (kind == 1 && c >= t4s && c < t4s + aw) alu_done = 1'b0;
            else if (kind == 1 && c == t4s + aw)       alu_done = 1'b1;
            else                                       alu_done = 1'($urandom);
            if (c > mw + 3) ir_q = $urandom;
        end
        @(negedge clock);
        #1;
    endtask

    initial begin
        logic [4:0] ops[12];
        logic [4:0] op;
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd15, 5'd16, 5'd17, 5'd18};
        clear = 1'b1; start = 1'b0; ir_q = '0; mem_ready = 1'b0; alu_done = 1'b0;
        @(posedge clock); #1;
        exp_now = '0;
        exp_now.aop_chk = 1'b1;
        exp_valid = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear = 1'b0;
        start = 1'b0;
        @(posedge clock); #1;

        run(32'h18918000, 0, 0, 0, 1);
        run(32'h78228000, 2, 3, 0, 2);
        run(32'h93C80000, 0, 0, 0, 3);
        run(32'hF8000000, 0, 0, 0, 4);
        run({5'b01111, 27'($urandom)}, 1, 5, 7, 0);
        run(32'h18918000, 0, 0, 0, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) op = 5'($urandom);
            else                           op = ops[$urandom_range(0, 11)];
            run({op, 27'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 4), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
